// File: rtl/nn_sequencer_if.sv
// Host/datapath handshake bundle for nn_sequencer: job control in,
// SRAM addresses, MAC strobes and status out.
interface nn_sequencer_if;
   logic        start;
   logic        abort;
   logic        mac1_done;
   logic        mac2_done;
   logic [17:0] address_1;
   logic [11:0] address_2;
   logic [9:0]  address_3;
   logic [5:0]  address_4;
   logic        mac1_start;
   logic        mac2_start;
   logic        we_out;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      input  start, abort, mac1_done, mac2_done,
      output address_1, address_2, address_3, address_4,
      output mac1_start, mac2_start, we_out, busy, done, error
   );

   modport slave (
      output start, abort, mac1_done, mac2_done,
      input  address_1, address_2, address_3, address_4,
      input  mac1_start, mac2_start, we_out, busy, done, error
   );
endinterface

// File: rtl/nn_sequencer.sv
// Two-layer inference control FSM: streams SRAM addresses, pulses MAC starts,
// writes the output SRAM and watches for MAC completions that never arrive.
module nn_sequencer #(
   parameter int N_IN    = 784,
   parameter int N_HID   = 100,
   parameter int N_OUT   = 10,
   parameter int W1_BASE = 0,
   parameter int SIG_LAT = 2,
   parameter int TIMEOUT = 4096
) (
   input logic           clk,
   input logic           reset,
   nn_sequencer_if.master bus
);
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_L1_RUN  = 4'd1;
   localparam logic [3:0] S_L1_WAIT = 4'd2;
   localparam logic [3:0] S_SIG1    = 4'd3;
   localparam logic [3:0] S_L2_RUN  = 4'd4;
   localparam logic [3:0] S_L2_WAIT = 4'd5;
   localparam logic [3:0] S_SIG2    = 4'd6;
   localparam logic [3:0] S_WR_OUT  = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   localparam int KW = 16;
   localparam int WW = $clog2(TIMEOUT) + 1;

   logic [3:0]    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [17:0]   a1_q, a1_d;
   logic [11:0]   a2_q, a2_d;
   logic [9:0]    a3_q, a3_d;
   logic [5:0]    a4_q, a4_d;
   logic          m1s_q, m1s_d, m2s_q, m2s_d, we_q, we_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic          wd_expired;

   assign wd_expired = (wd_q == WW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      k_d     = k_q + 1'b1;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            k_d = '0;
            if (bus.start) begin
               state_d = S_L1_RUN;
               err_d   = 1'b0;
            end
         end
         S_L1_RUN: if (k_q == KW'(N_IN - 1)) begin state_d = S_L1_WAIT; k_d = '0; end
         S_L1_WAIT: begin
            k_d = '0;
            // a done arriving on the last allowed cycle still counts
            if (bus.mac1_done)   state_d = S_SIG1;
            else if (wd_expired) begin state_d = S_IDLE; err_d = 1'b1; end
         end
         S_SIG1:   if (k_q == KW'(SIG_LAT - 1)) begin state_d = S_L2_RUN; k_d = '0; end
         S_L2_RUN: if (k_q == KW'(N_HID - 1)) begin state_d = S_L2_WAIT; k_d = '0; end
         S_L2_WAIT: begin
            k_d = '0;
            if (bus.mac2_done)   state_d = S_SIG2;
            else if (wd_expired) begin state_d = S_IDLE; err_d = 1'b1; end
         end
         S_SIG2:   if (k_q == KW'(SIG_LAT - 1)) begin state_d = S_WR_OUT; k_d = '0; end
         S_WR_OUT: if (k_q == KW'(N_OUT - 1)) begin state_d = S_DONE; k_d = '0; end
         S_DONE:   begin state_d = S_IDLE; k_d = '0; end
         default:  begin state_d = S_IDLE; k_d = '0; end
      endcase
      if (bus.abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         k_d     = '0;
         err_d   = err_q;
      end
   end

   always_comb begin
      wd_d = '0;
      if ((state_q == S_L1_WAIT || state_q == S_L2_WAIT) && state_d == state_q)
         wd_d = wd_q + 1'b1;
   end

   // Outputs are computed from the next state so every flop is a pure Moore output.
   always_comb begin
      a1_d   = a1_q;
      a2_d   = a2_q;
      a3_d   = a3_q;
      a4_d   = a4_q;
      case (state_d)
         S_IDLE:   begin a1_d = '0; a2_d = '0; a3_d = '0; a4_d = '0; end
         S_L1_RUN: begin a3_d = k_d[9:0]; a1_d = 18'(W1_BASE) + 18'(k_d); end
         S_L2_RUN: a2_d = k_d[11:0];
         S_WR_OUT: a4_d = k_d[5:0];
         default:  ;
      endcase
      m1s_d  = (state_d == S_L1_RUN) && (k_d == '0);
      m2s_d  = (state_d == S_L2_RUN) && (k_d == '0);
      we_d   = (state_d == S_WR_OUT);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         wd_q    <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         a3_q    <= '0;
         a4_q    <= '0;
         m1s_q   <= 1'b0;
         m2s_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         wd_q    <= wd_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         a3_q    <= a3_d;
         a4_q    <= a4_d;
         m1s_q   <= m1s_d;
         m2s_q   <= m2s_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.address_1  = a1_q;
   assign bus.address_2  = a2_q;
   assign bus.address_3  = a3_q;
   assign bus.address_4  = a4_q;
   assign bus.mac1_start = m1s_q;
   assign bus.mac2_start = m2s_q;
   assign bus.we_out     = we_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.error      = err_q;
endmodule

// File: tb/tb_nn_sequencer.sv
// Randomized job-level bench for nn_sequencer: a phase-by-phase trace model
// predicts every output for every cycle of each job.
module tb_nn_sequencer;
   localparam int N_IN    = 4;
   localparam int N_HID   = 3;
   localparam int N_OUT   = 2;
   localparam int W1_BASE = 8;
   localparam int SIG_LAT = 2;
   localparam int TIMEOUT = 8;

   typedef struct {
      bit          st, ab, m1, m2;
      logic [51:0] exp;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   nn_sequencer_if ifc();

   nn_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W1_BASE(W1_BASE),
                  .SIG_LAT(SIG_LAT), .TIMEOUT(TIMEOUT))
      dut (.clk(clk), .reset(reset), .bus(ifc));

   always #5 clk = ~clk;

   logic [51:0] obs;
   assign obs = {ifc.address_1, ifc.address_2, ifc.address_3, ifc.address_4,
                 ifc.mac1_start, ifc.mac2_start, ifc.we_out, ifc.busy, ifc.done, ifc.error};

   int   n_chk = 0, n_pass = 0;
   ent_t tr[$];
   bit   model_err = 1'b0;
   int   l2_idx, wr_idx;
   int   n_done, n_m1s, n_m2s, done_at;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, want);
   endtask

   function automatic ent_t mk(bit st, bit ab, bit m1, bit m2, logic [17:0] a1,
                               logic [11:0] a2, logic [9:0] a3, logic [5:0] a4,
                               bit m1s, bit m2s, bit we, bit busy, bit dn, bit err);
      ent_t e;
      e.st = st; e.ab = ab; e.m1 = m1; e.m2 = m2;
      e.exp = {a1, a2, a3, a4, m1s, m2s, we, busy, dn, err};
      return e;
   endfunction

   // One job as a list of cycles: entry 0 is the IDLE cycle whose edge samples start.
   // d1/d2: WAIT cycles before the MAC done is presented (>= TIMEOUT means never).
   task automatic build_job(input int d1, input int d2, input bit hold, input int spur);
      logic [17:0] a1;
      logic [11:0] a2;
      logic [9:0]  a3;
      logic [5:0]  a4;
      bit to;
      a1 = '0; a2 = '0; a3 = '0; a4 = '0;
      tr.delete();
      tr.push_back(mk(1, 0, 0, 0, a1, a2, a3, a4, 0, 0, 0, 0, 0, model_err));
      for (int k = 0; k < N_IN; k++) begin
         a3 = 10'(k); a1 = 18'(W1_BASE + k);
         tr.push_back(mk(hold, 0, k == spur, 0, a1, a2, a3, a4, k == 0, 0, 0, 1, 0, 0));
      end
      to = (d1 >= TIMEOUT);
      for (int w = 0; w < (to ? TIMEOUT : d1 + 1); w++)
         tr.push_back(mk(hold, 0, w == d1, 0, a1, a2, a3, a4, 0, 0, 0, 1, 0, 0));
      if (!to) begin
         for (int s = 0; s < SIG_LAT; s++)
            tr.push_back(mk(hold, 0, 0, 0, a1, a2, a3, a4, 0, 0, 0, 1, 0, 0));
         l2_idx = tr.size();
         for (int k = 0; k < N_HID; k++) begin
            a2 = 12'(k);
            tr.push_back(mk(hold, 0, 0, 0, a1, a2, a3, a4, 0, k == 0, 0, 1, 0, 0));
         end
         to = (d2 >= TIMEOUT);
         for (int w = 0; w < (to ? TIMEOUT : d2 + 1); w++)
            tr.push_back(mk(hold, 0, 0, w == d2, a1, a2, a3, a4, 0, 0, 0, 1, 0, 0));
         if (!to) begin
            for (int s = 0; s < SIG_LAT; s++)
               tr.push_back(mk(hold, 0, 0, 0, a1, a2, a3, a4, 0, 0, 0, 1, 0, 0));
            wr_idx = tr.size();
            for (int k = 0; k < N_OUT; k++) begin
               a4 = 6'(k);
               tr.push_back(mk(hold, 0, 0, 0, a1, a2, a3, a4, 0, 0, 1, 1, 0, 0));
            end
            tr.push_back(mk(hold, 0, 0, 0, a1, a2, a3, a4, 0, 0, 0, 1, 1, 0));
         end
      end
      model_err = to;
   endtask

   // Abort raised during cycle a: the job ends there and error stays clear.
   task automatic apply_abort(input int a);
      if (a > 0 && a < tr.size()) begin
         while (tr.size() > a + 1) void'(tr.pop_back());
         tr[a].ab = 1'b1;
         model_err = 1'b0;
      end
   endtask

   task automatic run_trace(input int upto);
      n_done = 0; n_m1s = 0; n_m2s = 0; done_at = -1;
      for (int i = 0; i < tr.size() && i < upto; i++) begin
         @(negedge clk);
         ifc.start = tr[i].st; ifc.abort = tr[i].ab;
         ifc.mac1_done = tr[i].m1; ifc.mac2_done = tr[i].m2;
         chk($sformatf("cyc%0d", i), 64'(obs), 64'(tr[i].exp));
         if (ifc.done) begin n_done++; if (done_at < 0) done_at = i; end
         if (ifc.mac1_start) n_m1s++;
         if (ifc.mac2_start) n_m2s++;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ifc.start = 0; ifc.abort = 0; ifc.mac1_done = 0; ifc.mac2_done = 0;
         chk("idle", 64'(obs), 64'({46'd0, 5'd0, model_err}));
      end
   endtask

   initial begin
      int m1_total, d1, d2, a, gap;
      bit hold;
      ifc.start = 0; ifc.abort = 0; ifc.mac1_done = 0; ifc.mac2_done = 0;
      #1 chk("reset_state", 64'(obs), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_cycles(2);

      // nominal job, each done presented in the first WAIT cycle
      build_job(0, 0, 0, -1);
      run_trace(1000);
      chk("latency", 64'(done_at), 64'(N_IN + 1 + SIG_LAT + N_HID + 1 + SIG_LAT + N_OUT + 1));
      chk("done_once", 64'(n_done), 64'd1);
      idle_cycles(1);

      // start held high across two jobs
      m1_total = 0;
      for (int j = 0; j < 2; j++) begin
         build_job(1, 0, 1, -1);
         run_trace(1000);
         m1_total += n_m1s;
      end
      chk("m1s_per_job", 64'(m1_total), 64'd2);
      idle_cycles(1);

      // watchdog with spurious early done, then recovery via start
      build_job(100, 0, 0, 2);
      run_trace(1000);
      chk("wd_no_done", 64'(n_done), 64'd0);
      chk("wd_no_m2s", 64'(n_m2s), 64'd0);
      idle_cycles(2);
      chk("wd_error", 64'(ifc.error), 64'd1);
      build_job(3, 2, 0, N_IN - 1);
      run_trace(1000);
      idle_cycles(1);

      // abort in WR_OUT at k=0
      build_job(0, 0, 0, -1);
      apply_abort(wr_idx);
      run_trace(1000);
      chk("abort_no_done", 64'(n_done), 64'd0);
      idle_cycles(2);

      // async reset mid-L2_RUN, between edges
      build_job(0, 0, 0, -1);
      run_trace(l2_idx + 2);
      #1 reset = 1'b1;
      #1 chk("async_rst", 64'(obs), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      model_err = 1'b0;
      idle_cycles(3);
      build_job(0, 1, 0, -1);
      run_trace(1000);
      idle_cycles(1);

      // randomized jobs
      for (int j = 0; j < 40; j++) begin
         d1 = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 6));
         d2 = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 6));
         hold = ($urandom_range(0, 3) == 0);
         build_job(d1, d2, hold, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N_IN - 1)) : -1);
         if ($urandom_range(0, 3) == 0) begin
            a = int'($urandom_range(1, tr.size() - 1));
            apply_abort(a);
         end
         run_trace(1000);
         gap = hold ? 0 : int'($urandom_range(0, 2));
         idle_cycles(gap);
      end
      idle_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
- Control FSM for the two-layer inference datapath (input/weight SRAMs -> MAC -> sigmoid -> MAC2 -> sigmoid -> output SRAM).
- Sits directly upstream of the datapath top. Generates SRAM addresses, MAC start pulses and the output-SRAM write enable, and consumes the MAC done flags.
- Gives the host a start/busy/done handshake, plus a watchdog error when a MAC done never arrives.

Parameters:
- N_IN, 784, input words per lane streamed in layer 1; must be ≤ 1024.
- N_HID, 100, hidden words streamed in layer 2; must be ≤ 4096.
- N_OUT, 10, output-SRAM words written per job; must be ≤ 64.
- W1_BASE, 0, first sram_weight1 address of the job.
- SIG_LAT, 2, cycles from a MAC done to valid sigmoid output; must be ≥ 1.
- TIMEOUT, 4096, maximum wait cycles for a MAC done.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  host job request, level-sampled in IDLE only.
- abort  in  1  synchronous abort; returns to IDLE.
- mac1_done  in  1  layer-1 MAC complete.
- mac2_done  in  1  layer-2 MAC complete.
- address_1  out  18  sram_weight1 address.
- address_2  out  12  sram_weight2 address.
- address_3  out  10  sram_input address.
- address_4  out  6  sram_output address.
- mac1_start  out  1  one-cycle start pulse to layer-1 MACs.
- mac2_start  out  1  one-cycle start pulse to layer-2 MACs.
- we_out  out  1  output-SRAM write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle job-complete pulse.
- error  out  1  sticky watchdog flag; cleared by reset or by the next accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter k = 0, wait counter = 0.
- All outputs are registered (Moore): each output reflects the current state and k.
- States and transitions:
  - IDLE: if start=1, go to L1_RUN, k=0, error cleared.
  - L1_RUN (N_IN cycles):
    - address_3 = k, address_1 = W1_BASE + k (18-bit wrap-around).
    - mac1_start = 1 only when k = 0.
    - At k = N_IN-1, go to L1_WAIT.
  - L1_WAIT:
    - mac1_done=1 -> SIG1 (SIG_LAT cycles) -> L2_RUN, k=0.
    - mac1_done is sampled in L1_WAIT only; a done seen during L1_RUN is ignored.
  - L2_RUN (N_HID cycles):
    - address_2 = k.
    - mac2_start = 1 only when k = 0.
    - At k = N_HID-1, go to L2_WAIT.
  - L2_WAIT: mac2_done=1 -> SIG2 (SIG_LAT cycles) -> WR_OUT, k=0.
  - WR_OUT (N_OUT cycles):
    - we_out = 1, address_4 = k.
    - At k = N_OUT-1, go to DONE.
  - DONE (1 cycle): done = 1, busy = 1; next state IDLE.
- Addresses hold their last driven value outside their owning state. They return to 0 only in IDLE.
- start is ignored while busy; no queuing.
- Watchdog:
  - The wait counter increments each cycle in L1_WAIT and L2_WAIT and clears on state exit.
  - When the counter reaches TIMEOUT-1 with no done, error is set and the FSM goes to IDLE; done is not pulsed.
- abort=1 in any non-IDLE state: next state IDLE; we_out, mac1_start and mac2_start are 0 in that next cycle; done is not pulsed; error is unchanged.
- Priority, highest first: reset > abort > watchdog > normal transition.
- mac done and abort in the same cycle: abort wins.
- Reset asserted mid-job: all outputs 0 asynchronously, without waiting for a clock edge. No partial write continues after reset.
- Job latency with immediate done responses:
  - N_IN + 1 + SIG_LAT + N_HID + 1 + SIG_LAT + N_OUT + 1 cycles from the start-sampling edge to the done pulse.
  - Each WAIT state takes at least 1 cycle.

Test Plan:
- Nominal job (params N_IN=4, N_HID=3, N_OUT=2, SIG_LAT=2, W1_BASE=8):
  - Stimulus: start for 1 cycle; mac1_done and mac2_done each returned 1 cycle after entering WAIT.
  - Required: address_3 = 0,1,2,3 and address_1 = 8,9,10,11; address_2 = 0,1,2; we_out high for 2 cycles with address_4 = 0,1.
  - Required: done pulses exactly once, 16 cycles after the start edge; busy falls the cycle after done.
- Start held high through a whole job and into IDLE:
  - Required: exactly one job per IDLE visit.
  - Required: mac1_start pulses once per job, never during L1_RUN beats k>0.
- Watchdog (TIMEOUT=8): mac1_done never asserted.
  - Required: error=1 after 8 L1_WAIT cycles, state IDLE, no done pulse, no mac2_start.
  - Required: the next start clears error.
- Abort in WR_OUT at k=0:
  - Required: we_out=0 the following cycle, busy=0, done never pulses, address_4 = 0.
- Async reset asserted mid-L2_RUN between clock edges:
  - Required: all outputs 0 immediately; after release the FSM idles until start.
- Spurious mac1_done during L1_RUN, then no done in L1_WAIT:
  - Required: the FSM stays in L1_WAIT (the early done is ignored) until a done arrives or the watchdog fires.
